// File: rtl/ram_wait.sv
// rtl/ram_wait.sv - single-port byte-enabled word RAM with req/ready handshake and wait states
module ram_wait #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 7,
   parameter int DEPTH       = 128,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic                  err
);

   localparam int NB = DATA_W / 8;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state, state_nx;
   logic [3:0]          cnt, cnt_nx;
   logic                capture, access;

   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NB-1:0]       be_q;

   logic                we_a;
   logic [ADDR_W-1:0]   addr_a;
   logic [DATA_W-1:0]   wdata_a;
   logic [NB-1:0]       be_a;
   logic                in_range;

   logic [DATA_W-1:0]   mem [DEPTH];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      access   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               capture = 1'b1;
               if (WAIT_STATES == 0) begin
                  access   = 1'b1;
                  state_nx = RESP;
               end else begin
                  cnt_nx   = CNT_INIT;
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               access   = 1'b1;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Zero-wait accesses happen at the accept edge, so they use the live inputs.
   always_comb begin
      we_a    = (state == IDLE) ? we    : we_q;
      addr_a  = (state == IDLE) ? addr  : addr_q;
      wdata_a = (state == IDLE) ? wdata : wdata_q;
      be_a    = (state == IDLE) ? be    : be_q;
      in_range = ({1'b0, addr_a} < (ADDR_W + 1)'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         ready <= access;
         err   <= access && !in_range;
         if (capture) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
         end
         if (access && !we_a)
            rdata <= in_range ? mem[addr_a] : '0;
      end
   end

   // Storage is never reset; a write is suppressed while rst is high so aborts leave it intact.
   always_ff @(posedge clk) begin
      if (!rst && access && we_a && in_range) begin
         for (int i = 0; i < NB; i++)
            if (be_a[i])
               mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_ram_wait.sv
// tb/tb_ram_wait.sv - scoreboard bench for ram_wait with zero-wait and three-wait instances
module tb_ram_wait;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [6:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        req0, req3;
   logic [31:0] rd0, rd3;
   logic        rdy0, rdy3, er0, er3;

   exp_t        q0[$];
   exp_t        q3[$];
   logic [31:0] m0 [128];
   logic [31:0] m3 [128];
   logic [31:0] lr0 = '0;
   logic [31:0] lr3 = '0;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_wait #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .WAIT_STATES(0)) d0 (
      .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .rdata(rd0), .ready(rdy0), .err(er0));

   ram_wait #(.DATA_W(32), .ADDR_W(7), .DEPTH(128), .WAIT_STATES(3)) d3 (
      .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .rdata(rd3), .ready(rdy3), .err(er3));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic push(input int k, input logic w, input logic [6:0] a,
                       input logic [31:0] d, input logic [3:0] b, input int ecyc);
      exp_t        e;
      logic [31:0] mv;
      int          dep;
      dep = (k == 0) ? 100 : 128;
      mv  = (k == 0) ? m0[a] : m3[a];
      if (w) begin
         if (int'(a) < dep) begin
            for (int i = 0; i < 4; i++)
               if (b[i]) mv[8*i +: 8] = d[8*i +: 8];
            if (k == 0) m0[a] = mv; else m3[a] = mv;
         end
         e.rd = (k == 0) ? lr0 : lr3;
      end else begin
         e.rd = (int'(a) < dep) ? mv : 32'h0;
         if (k == 0) lr0 = e.rd; else lr3 = e.rd;
      end
      e.er  = (int'(a) >= dep);
      e.cyc = ecyc;
      if (k == 0) q0.push_back(e); else q3.push_back(e);
   endtask

   task automatic mon(input int k, input logic r, input logic [31:0] d, input logic e);
      exp_t x;
      if (r) begin
         if ((k == 0 && q0.size() == 0) || (k == 3 && q3.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_ready_d%0d got=1 exp=0", k);
         end else begin
            if (k == 0) x = q0.pop_front(); else x = q3.pop_front();
            chk($sformatf("rdata_d%0d", k), d, x.rd);
            chk($sformatf("err_d%0d", k), {31'b0, e}, {31'b0, x.er});
            chk($sformatf("ready_cycle_d%0d", k), cyc, x.cyc);
         end
      end else if (e) begin
         failures++;
         $display("FAIL err_without_ready_d%0d got=1 exp=0", k);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, rdy0, rd0, er0);
         mon(3, rdy3, rd3, er3);
      end
   end

   task automatic issue(input int k, input logic w, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      we = w; addr = a; wdata = d; be = b;
      if (k == 0) req0 = 1'b1; else req3 = 1'b1;
      @(posedge clk); #1;
      push(k, w, a, d, b, cyc + ((k == 0) ? 0 : 3));
      req0 = 1'b0; req3 = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (((k == 0) ? q0.size() : q3.size()) != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (((k == 0) ? q0.size() : q3.size()) != 0) begin
         failures++;
         $display("FAIL ready_timeout_d%0d got=none exp=ready", k);
         if (k == 0) q0.delete(); else q3.delete();
      end
   endtask

   task automatic rw(input int k, input logic w, input logic [6:0] a,
                     input logic [31:0] d, input logic [3:0] b);
      issue(k, w, a, d, b);
      wait_done(k);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req3 = 1'b0;
      we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      chk("reset_rdata", rd0, 32'h0);
      chk("reset_ready", {31'b0, rdy0}, 32'h0);
      chk("reset_err", {31'b0, er3}, 32'h0);
      @(posedge clk); #1;

      repeat (10) begin
         @(negedge clk);
         chk("idle_ready_d0", {31'b0, rdy0}, 32'h0);
         chk("idle_ready_d3", {31'b0, rdy3}, 32'h0);
      end
      @(posedge clk); #1;

      rw(0, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF);
      rw(0, 1'b0, 7'd5, 32'h0, 4'h0);
      chk("basic_read", rd0, 32'hDEADBEEF);
      rw(0, 1'b1, 7'd5, 32'h11223344, 4'b0101);
      rw(0, 1'b0, 7'd5, 32'h0, 4'hF);
      chk("byte_enable_read", rd0, 32'hDE22BE44);
      rw(0, 1'b1, 7'd5, 32'hFFFFFFFF, 4'h0);
      rw(0, 1'b0, 7'd5, 32'h0, 4'h0);
      chk("zero_be_read", rd0, 32'hDE22BE44);

      rw(0, 1'b1, 7'd0, 32'h11110000, 4'hF);
      rw(0, 1'b1, 7'd99, 32'h99990099, 4'hF);
      rw(0, 1'b0, 7'd120, 32'h0, 4'h0);
      chk("oor_read_rdata", rd0, 32'h0);
      rw(0, 1'b1, 7'd120, 32'hFFFFFFFF, 4'hF);
      rw(0, 1'b0, 7'd0, 32'h0, 4'h0);
      rw(0, 1'b0, 7'd5, 32'h0, 4'h0);
      rw(0, 1'b0, 7'd99, 32'h0, 4'h0);
      chk("oor_write_kept_99", rd0, 32'h99990099);

      @(negedge clk); #1 rst = 1'b1;
      #1;
      chk("async_reset_rdata", rd0, 32'h0);
      chk("async_reset_ready", {31'b0, rdy0}, 32'h0);
      chk("async_reset_err", {31'b0, er0}, 32'h0);
      lr0 = '0; lr3 = '0;
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;

      rw(3, 1'b1, 7'd9, 32'h0, 4'hF);
      rw(3, 1'b1, 7'd3, 32'h12345678, 4'hF);
      rw(3, 1'b0, 7'd9, 32'h0, 4'h0);

      // req and addr wiggle while the read sits in WAIT
      we = 1'b0; addr = 7'd3; req3 = 1'b1;
      @(posedge clk); #1;
      push(3, 1'b0, 7'd3, 32'h0, 4'h0, cyc + 3);
      req3 = 1'b0; addr = 7'd9;
      @(posedge clk); #1;
      req3 = 1'b1; addr = 7'd0; we = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      wait_done(3);
      chk("wait_toggle_read", rd3, 32'h12345678);

      we = 1'b0; addr = 7'd3; req3 = 1'b1;
      @(posedge clk); #1;
      push(3, 1'b0, 7'd3, 32'h0, 4'h0, cyc + 3);
      addr = 7'd9;
      repeat (5) @(posedge clk);
      #1;
      push(3, 1'b0, 7'd9, 32'h0, 4'h0, cyc + 3);
      req3 = 1'b0;
      wait_done(3);
      chk("b2b_second_read", rd3, 32'h0);

      we = 1'b1; addr = 7'd9; wdata = 32'hCAFEF00D; be = 4'hF; req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      lr0 = '0; lr3 = '0;
      @(posedge clk); #3 rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_ready", {31'b0, rdy3}, 32'h0);
      end
      @(posedge clk); #1;
      rw(3, 1'b0, 7'd9, 32'h0, 4'h0);
      chk("abort_mem_kept", rd3, 32'h0);

      chk("queue_d0_empty", q0.size(), 32'h0);
      chk("queue_d3_empty", q3.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
